// File: rtl/rf_wb_arb.sv
// Purpose : merges the load-return and ALU writeback sources into the single RF write port.
// Latency : 1 cycle from accept (load or bypassed ALU) or from FIFO pop to registered we/dst.
// Backpr. : alu_rdy drops when the ALU FIFO is full; ld_rdy drops for one cycle when the starvation guard fires.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   alu_vld/alu_rdy/alu_addr/data ALU writeback request (lower priority, queued on loss)
//   ld_vld/ld_rdy/ld_addr/ld_data load-return writeback request (higher priority)
//   chk_addr -> chk_hit           combinational "write still in flight" hazard lookup
//   we, dst_addr, dst             registered RF write port
//   qcnt                          ALU FIFO occupancy, 0..DEPTH
module rf_wb_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_vld,
  input  logic [3:0]                   alu_addr,
  input  logic [15:0]                  alu_data,
  output logic                         alu_rdy,
  input  logic                         ld_vld,
  input  logic [3:0]                   ld_addr,
  input  logic [15:0]                  ld_data,
  output logic                         ld_rdy,
  input  logic [3:0]                   chk_addr,
  output logic                         chk_hit,
  output logic                         we,
  output logic [3:0]                   dst_addr,
  output logic [15:0]                  dst,
  output logic [$clog2(DEPTH+1)-1:0]   qcnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] QFULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wb_t;

  // FIFO storage and bookkeeping
  wb_t           fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [SW-1:0] starve;
  logic [CW-1:0] qcnt_nxt;

  // Arbitration decode
  logic          q_empty;
  logic          guard;
  logic          alu_acc;
  logic          ld_acc;
  logic          ld_win;
  logic          pop;
  logic          push;
  logic          sel_we;
  wb_t           sel;
  wb_t           head;

  // Hazard lookup scratch
  logic [AW-1:0] slot;
  logic          hit;

  assign q_empty = (qcnt == '0);
  assign guard   = (qcnt == QFULL) && (starve == SMAX);

  // Both ready signals come from registered state only, so no vld->rdy path exists.
  assign alu_rdy = (qcnt != QFULL);
  assign ld_rdy  = !guard;

  assign alu_acc = alu_vld && alu_rdy;
  assign ld_acc  = ld_vld && ld_rdy;
  assign head    = fifo_mem[rd_ptr];

  // Output select, highest priority first. A load to r0 falls through so the
  // FIFO can still drain that cycle.
  always_comb begin
    sel_we = 1'b0;
    sel    = head;
    pop    = 1'b0;
    push   = 1'b0;
    ld_win = 1'b0;

    if (guard) begin
      sel_we = 1'b1;
      pop    = 1'b1;
    end else if (ld_acc && (ld_addr != 4'd0)) begin
      sel_we = 1'b1;
      ld_win = 1'b1;
      sel    = '{addr: ld_addr, data: ld_data};
      push   = alu_acc && (alu_addr != 4'd0);
    end else if (!q_empty) begin
      sel_we = 1'b1;
      pop    = 1'b1;
      push   = alu_acc && (alu_addr != 4'd0);
    end else if (alu_acc && (alu_addr != 4'd0)) begin
      // Empty FIFO: skip the queue entirely to keep ALU latency at one cycle.
      sel_we = 1'b1;
      sel    = '{addr: alu_addr, data: alu_data};
    end
  end

  always_comb begin
    qcnt_nxt = qcnt;
    case ({push, pop})
      2'b10:   qcnt_nxt = qcnt + CW'(1);
      2'b01:   qcnt_nxt = qcnt - CW'(1);
      default: qcnt_nxt = qcnt;
    endcase
  end

  // FIFO payload carries no reset; validity is tracked by qcnt/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: alu_addr, data: alu_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      qcnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      qcnt <= qcnt_nxt;
    end
  end

  // Starvation counter: counts load wins that left a non-empty FIFO waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (ld_win && !q_empty) begin
      if (starve != SMAX) begin
        starve <= starve + SW'(1);
      end
    end else if (pop || q_empty) begin
      starve <= '0;
    end
  end

  // Registered RF write port; address/data hold when no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we       <= 1'b0;
      dst_addr <= 4'd0;
      dst      <= 16'd0;
    end else begin
      we <= sel_we;
      if (sel_we) begin
        dst_addr <= sel.addr;
        dst      <= sel.data;
      end
    end
  end

  // Hazard lookup over the live FIFO window [rd_ptr, rd_ptr+qcnt) plus the
  // output register. r0 is never written, so it never hazards.
  always_comb begin
    hit  = 1'b0;
    slot = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + AW'(i);
      if ((CW'(i) < qcnt) && (fifo_mem[slot].addr == chk_addr)) begin
        hit = 1'b1;
      end
    end
    if (we && (dst_addr == chk_addr)) begin
      hit = 1'b1;
    end
    if (chk_addr == 4'd0) begin
      hit = 1'b0;
    end
  end

  assign chk_hit = hit;

endmodule

// File: tb/tb_rf_wb_arb.sv
// Purpose : randomized + directed bench for rf_wb_arb against a queue-based reference model.
// Latency : model predicts registered outputs one cycle after each applied input vector.
// Backpr. : drivers consult the model's ready predictions to know which ALU requests were taken.
module tb_rf_wb_arb;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_rdy;
  logic        ld_vld;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic        ld_rdy;
  logic [3:0]  chk_addr;
  logic        chk_hit;
  logic        we;
  logic [3:0]  dst_addr;
  logic [15:0] dst;
  logic [2:0]  qcnt;

  always #5 clk = ~clk;

  rf_wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .alu_vld  (alu_vld),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .alu_rdy  (alu_rdy),
    .ld_vld   (ld_vld),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_rdy   (ld_rdy),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .we       (we),
    .dst_addr (dst_addr),
    .dst      (dst),
    .qcnt     (qcnt)
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state: pending ALU writes in order, starvation count, RF port.
  ent_t        mq[$];
  int          m_starve;
  bit          m_we;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  ent_t        wlog[$];
  int          max_q = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_addr   = 4'd0;
    m_data   = 16'd0;
  endtask

  function automatic bit model_hit(input logic [3:0] ca);
    bit h;
    h = 1'b0;
    foreach (mq[i]) if (mq[i].a == ca) h = 1'b1;
    if (m_we && m_addr == ca) h = 1'b1;
    if (ca == 4'd0) h = 1'b0;
    return h;
  endfunction

  function automatic bit model_alu_ok();
    return mq.size() < DEPTH;
  endfunction

  // One clock of the arbitration rules, applied to the queue model.
  task automatic model_step(input bit av, input logic [3:0] aa, input logic [15:0] ad,
                            input bit lv, input logic [3:0] la, input logic [15:0] ld);
    int   pre;
    bit   guard;
    bit   ld_acc;
    bit   alu_acc;
    bit   push;
    ent_t h;
    pre     = mq.size();
    guard   = (pre == DEPTH) && (m_starve == STARVE_MAX);
    ld_acc  = lv && !guard;
    alu_acc = av && (pre < DEPTH);
    push    = 1'b0;
    m_we    = 1'b0;
    if (guard) begin
      h = mq.pop_front();
      m_we = 1'b1; m_addr = h.a; m_data = h.d;
      m_starve = 0;
    end else if (ld_acc && la != 4'd0) begin
      m_we = 1'b1; m_addr = la; m_data = ld;
      if (pre != 0 && m_starve < STARVE_MAX) m_starve++;
      push = alu_acc && (aa != 4'd0);
    end else if (pre != 0) begin
      h = mq.pop_front();
      m_we = 1'b1; m_addr = h.a; m_data = h.d;
      m_starve = 0;
      push = alu_acc && (aa != 4'd0);
    end else if (alu_acc && aa != 4'd0) begin
      m_we = 1'b1; m_addr = aa; m_data = ad;
    end
    if (pre == 0) m_starve = 0;
    if (push) mq.push_back({aa, ad});
  endtask

  // Drive one input vector at the negedge, compare every output with the model,
  // then advance the model past the coming posedge.
  task automatic step(input bit av, input logic [3:0] aa, input logic [15:0] ad,
                      input bit lv, input logic [3:0] la, input logic [15:0] ld,
                      input logic [3:0] ca);
    @(negedge clk);
    alu_vld = av; alu_addr = aa; alu_data = ad;
    ld_vld  = lv; ld_addr  = la; ld_data  = ld;
    chk_addr = ca;
    #1;
    check("we",       32'(we),       32'(m_we));
    check("dst_addr", 32'(dst_addr), 32'(m_addr));
    check("dst",      32'(dst),      32'(m_data));
    check("qcnt",     32'(qcnt),     32'(mq.size()));
    check("alu_rdy",  32'(alu_rdy),  32'(mq.size() < DEPTH));
    check("ld_rdy",   32'(ld_rdy),   32'(!(mq.size() == DEPTH && m_starve == STARVE_MAX)));
    check("chk_hit",  32'(chk_hit),  32'(model_hit(ca)));
    if (we) wlog.push_back({dst_addr, dst});
    if (int'(qcnt) > max_q) max_q = int'(qcnt);
    model_step(av, aa, ad, lv, la, ld);
  endtask

  task automatic idle(input logic [3:0] ca);
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, ca);
  endtask

  logic [3:0] ra;
  logic [3:0] rl;
  int         alu_n;
  int         k;
  bit         saw_block;
  bit         acc;

  initial begin
    rst = 1'b1;
    alu_vld = 1'b0; alu_addr = 4'd0; alu_data = 16'd0;
    ld_vld  = 1'b0; ld_addr  = 4'd0; ld_data  = 16'd0;
    chk_addr = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    idle(4'd5);
    check("rst_we",      32'(we),      32'd0);
    check("rst_alu_rdy", 32'(alu_rdy), 32'd1);
    check("rst_ld_rdy",  32'(ld_rdy),  32'd1);

    // Bypass
    step(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'd0, 4'd5);
    idle(4'd5);
    check("byp_we",   32'(we),       32'd1);
    check("byp_addr", 32'(dst_addr), 32'd5);
    check("byp_dst",  32'(dst),      32'hBEEF);
    check("byp_qcnt", 32'(qcnt),     32'd0);
    idle(4'd5);
    check("byp_we_lo", 32'(we), 32'd0);

    // Priority: load first, ALU queued
    step(1'b1, 4'd3, 16'h0003, 1'b1, 4'd7, 16'h0007, 4'd3);
    idle(4'd3);
    check("pri_addr", 32'(dst_addr), 32'd7);
    check("pri_dst",  32'(dst),      32'h0007);
    check("pri_qcnt", 32'(qcnt),     32'd1);
    check("pri_hit",  32'(chk_hit),  32'd1);
    idle(4'd3);
    check("pri2_we",   32'(we),       32'd1);
    check("pri2_addr", 32'(dst_addr), 32'd3);
    check("pri2_qcnt", 32'(qcnt),     32'd0);

    // Register 0 requests are absorbed
    step(1'b1, 4'd0, 16'h1234, 1'b1, 4'd0, 16'h5678, 4'd0);
    idle(4'd0);
    check("r0_we",   32'(we),      32'd0);
    check("r0_qcnt", 32'(qcnt),    32'd0);
    check("r0_hit",  32'(chk_hit), 32'd0);

    // Starvation guard: loads held high while four ALU writes pile up
    wlog.delete();
    alu_n = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 20; c++) begin
      acc = (alu_n < 4) && model_alu_ok();
      step(alu_n < 4, 4'(alu_n + 1), 16'hC000 + 16'(alu_n),
           1'b1, 4'd8 + 4'(c % 4), 16'h7000 + 16'(c), 4'(alu_n + 1));
      if (!ld_rdy) saw_block = 1'b1;
      if (acc) alu_n++;
    end
    for (int c = 0; c < 8; c++) idle(4'd1);
    check("stv_block", 32'(saw_block), 32'd1);
    k = 0;
    foreach (wlog[i]) if (wlog[i].d[15:12] == 4'hC) begin
      check("stv_order", 32'(wlog[i].a), 32'(k + 1));
      k++;
    end
    check("stv_count", 32'(k), 32'd4);

    // Wrap: ten ALU writes under alternating load traffic
    wlog.delete();
    max_q = 0;
    alu_n = 0;
    for (int c = 0; c < 80 && alu_n < 10; c++) begin
      acc = model_alu_ok();
      step(1'b1, 4'(alu_n + 1), 16'hA000 + 16'(alu_n),
           c[0], 4'd11 + 4'(c % 5), 16'h5000 + 16'(c), 4'($urandom_range(0, 15)));
      if (acc) alu_n++;
    end
    for (int c = 0; c < 8; c++) idle(4'd0);
    k = 0;
    foreach (wlog[i]) if (wlog[i].d[15:12] == 4'hA) begin
      check("wrap_order", 32'(wlog[i].a), 32'(k + 1));
      k++;
    end
    check("wrap_count", 32'(k), 32'd10);
    check("wrap_maxq",  32'(max_q <= DEPTH), 32'd1);

    // Reset mid-operation with three queued entries
    for (int c = 0; c < 3; c++)
      step(1'b1, 4'(c + 1), 16'hD000 + 16'(c), 1'b1, 4'd9, 16'h9000 + 16'(c), 4'd1);
    @(posedge clk);
    #2;
    check("pre_rst_q", 32'(qcnt), 32'd3);
    alu_vld = 1'b0;
    ld_vld  = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_we",      32'(we),      32'd0);
    check("mrst_qcnt",    32'(qcnt),    32'd0);
    check("mrst_alu_rdy", 32'(alu_rdy), 32'd1);
    check("mrst_ld_rdy",  32'(ld_rdy),  32'd1);
    for (int a = 0; a < 16; a++) begin
      chk_addr = 4'(a);
      #1;
      check("mrst_hit", 32'(chk_hit), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      ra = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rl = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 2) != 0, ra, 16'($urandom),
           $urandom_range(0, 3) != 0, rl, 16'($urandom),
           4'($urandom_range(0, 15)));
    end
    for (int c = 0; c < 8; c++) idle(4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Writeback arbiter that sits directly upstream of the 16x16 register file and drives its single write port (`we`, `dst_addr`, `dst`). It merges two writeback sources, the ALU result path and the load-return path, into one registered write per cycle. Load returns have priority. ALU results that lose arbitration wait in a small in-order FIFO, and a starvation guard forces the FIFO to drain. A hazard-check port tells issue logic whether a register still has a write in flight, so a read of that register would return stale data.

## Interface
- `DEPTH`, 4: ALU FIFO entries (power of two, ≥2)
- `STARVE_MAX`, 3: consecutive load wins with a non-empty FIFO before the guard engages
- `clk` in 1: clock; all state updates on posedge
- `rst` in 1: reset, asynchronous, active-high
- `alu_vld` in 1: ALU writeback request
- `alu_addr` in 4: ALU destination register
- `alu_data` in 16: ALU result
- `alu_rdy` out 1: ALU request accepted this cycle when `alu_vld & alu_rdy`
- `ld_vld` in 1: load-return writeback request
- `ld_addr` in 4: load destination register
- `ld_data` in 16: load data
- `ld_rdy` out 1: load accepted when `ld_vld & ld_rdy`
- `chk_addr` in 4: register number to hazard-check
- `chk_hit` out 1: a write to `chk_addr` is queued or in the output register
- `we` out 1: RF write enable (registered)
- `dst_addr` out 4: RF write address (registered)
- `dst` out 16: RF write data (registered)
- `qcnt` out 3: FIFO occupancy, 0..DEPTH

## Operation
- Handshakes:
  - `alu_rdy = (qcnt < DEPTH)`.
  - `ld_rdy = !(qcnt == DEPTH && starve == STARVE_MAX)`.
  - Neither depends on a `*_vld` input. Both are derived from registers only.
- Per-posedge selection for the output register, in priority order:
  1. Guard active (`qcnt==DEPTH && starve==STARVE_MAX`): pop the FIFO head and write it. The load is not accepted.
  2. Accepted load with `ld_addr != 0`: write the load. The FIFO holds.
  3. FIFO non-empty: pop the head and write it.
  4. Accepted ALU, FIFO empty, `alu_addr != 0`: bypass straight to the output register.
  5. Otherwise `we <= 0`. `dst_addr` and `dst` hold their previous values.
- An accepted ALU request that is neither bypassed nor dropped is pushed at the FIFO tail in the same cycle.
  - Push and pop in the same cycle are allowed.
  - `qcnt` is then unchanged and order is preserved.
- Address 0 requests:
  - They are handshaken normally, then discarded.
  - They are never enqueued and never produce `we=1`.
  - A discarded load does not block the FIFO pop (rule 3 applies).
- Starvation counter `starve`:
  - It increments (saturating at STARVE_MAX) on every rule-2 write while `qcnt != 0`.
  - It clears on any FIFO pop and whenever `qcnt == 0`.
- `chk_hit` is combinational. It is 1 if either of these targets `chk_addr`, and it is forced to 0 when `chk_addr == 0`:
  - any valid FIFO entry, or
  - the current output register with `we == 1`.
- No ordering is guaranteed between the load and ALU sources for the same register. Issue logic must use `chk_hit` to serialize such cases.
- FIFO pointers wrap modulo DEPTH, with occupancy kept in `qcnt`.

## Timing
- Reset (async assert, synchronous-to-posedge deassert use):
  - `we=0`, `dst_addr=0`, `dst=0`
  - `qcnt=0`, `starve=0`, FIFO pointers = 0
  - `alu_rdy=1`, `ld_rdy=1`, `chk_hit=0`
- Reset mid-operation discards all queued entries and any pending output write. `we` goes low immediately on `rst` assertion.
- Latency:
  - Load: accept edge → `we` high for exactly 1 cycle after that posedge.
  - Bypassed ALU: same, 1 cycle.
  - Queued ALU: 1 cycle after the edge that pops it.
- Outputs change only at posedge. The RF samples them at the following negedge, which gives half a cycle of setup.
- At most one RF write per cycle. `we` is never high for two cycles from one request.

## Test plan
- Reset: assert `rst` while FIFO holds 3 entries → `we=0`, `qcnt=0`, `alu_rdy=1`, `ld_rdy=1`, `chk_hit=0` for any `chk_addr`.
- Bypass: idle, ALU (addr 5, 16'hBEEF) → next cycle `we=1`, `dst_addr=5`, `dst=16'hBEEF`; the cycle after, `we=0`; `qcnt` stays 0.
- Priority and queue:
  - Same cycle: ALU (3, 16'h0003) and load (7, 16'h0007) → load written first, `qcnt=1`, `chk_hit=1` for `chk_addr=3`.
  - Next idle cycle: (3, 16'h0003) written, `qcnt=0`.
- Starvation guard:
  - Hold `ld_vld` high and push 4 ALU writes → `qcnt=4`, `alu_rdy=0`.
  - After 3 load writes, `ld_rdy=0` for one cycle and the FIFO head is written; `starve` resets.
  - ALU entries drain in push order.
- Register 0:
  - ALU and load both targeting addr 0 → both accepted, `we` stays 0, `qcnt` unchanged.
  - `chk_addr=0` → `chk_hit=0`.
- Wrap: push/pop 10 ALU writes (addr 1..10) under alternating load traffic → RF receives all 10 in order, and `qcnt` never exceeds 4.
